// File: rtl/heq_pkg.sv
// heq_pkg: shared constants and FSM state type for the histogram-equalization
// LUT builder.
//   DATA_W      pixel bit depth
//   PIXEL_COUNT pixels per frame
//   COUNT_W     width of cumulative-histogram values
//   NUM_W       divider dividend width (COUNT_W + DATA_W)
//   LUT_DEPTH   number of grey levels / LUT entries
//   MAX_LEVEL   largest grey level
package heq_pkg;

  localparam int DATA_W      = 8;
  localparam int PIXEL_COUNT = 640 * 480;
  localparam int COUNT_W     = $clog2(PIXEL_COUNT);
  localparam int NUM_W       = COUNT_W + DATA_W;
  localparam int LUT_DEPTH   = 1 << DATA_W;
  localparam int MAX_LEVEL   = LUT_DEPTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CALC,
    ST_DIV,
    ST_WRITE,
    ST_DONE
  } heq_state_t;

endpackage

// File: rtl/heq_seq_divider.sv
// heq_seq_divider: restoring unsigned divider, one quotient bit per cycle.
//   i_clk      clock
//   i_reset_n  synchronous active-low reset
//   i_load     load i_num / i_den and start a division
//   i_num      dividend (NumWidth bits)
//   i_den      divisor (DenWidth bits, must be non-zero)
//   o_quot     quotient; final once the step following o_valid has completed
//   o_valid    1-cycle pulse NumWidth cycles after i_load (last step cycle)
module heq_seq_divider
  import heq_pkg::*;
#(
  parameter int NumWidth = NUM_W,
  parameter int DenWidth = COUNT_W
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_load,
  input  logic [NumWidth-1:0] i_num,
  input  logic [DenWidth-1:0] i_den,
  output logic [NumWidth-1:0] o_quot,
  output logic                o_valid
);

  localparam int CntWidth = $clog2(NumWidth + 1);

  logic [NumWidth-1:0] r_quot;
  logic [DenWidth-1:0] r_rem;
  logic [DenWidth-1:0] r_den;
  logic [CntWidth-1:0] r_cnt;

  // The trial remainder is {r_rem, next dividend bit}. If the bit shifted out
  // of r_rem is set, the trial exceeds any DenWidth-bit divisor, so the
  // comparison only needs the low DenWidth bits; the modular subtraction
  // then yields the exact remainder, which is always below r_den.
  logic [DenWidth-1:0] w_low;
  logic                w_ge;

  assign w_low   = {r_rem[DenWidth-2:0], r_quot[NumWidth-1]};
  assign w_ge    = r_rem[DenWidth-1] | (w_low >= r_den);
  assign o_quot  = r_quot;
  assign o_valid = (r_cnt == CntWidth'(1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_quot <= i_num;
      r_rem  <= '0;
      r_den  <= i_den;
      r_cnt  <= CntWidth'(NumWidth);
    end else if (r_cnt != '0) begin
      r_rem  <= w_ge ? (w_low - r_den) : w_low;
      r_quot <= {r_quot[NumWidth-2:0], w_ge};
      r_cnt  <= r_cnt - CntWidth'(1);
    end
  end

endmodule

// File: rtl/heq_lut_builder.sv
// heq_lut_builder: builds the histogram-equalization remap LUT from the
// cumulative histogram, lut[v] = (cdf[v]-cdfMin)*(2^DataWidth-1)/(N-cdfMin).
// Optional build macro HEQ_ROUND_EN: add den/2 before dividing (round half
// up); without it the quotient is truncated. Latency is the same either way.
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_start, i_cdf_min start pulse and cdfMin (sampled when start accepted)
//   o_cdf_addr, o_cdf_rd_en, i_cdf_data   CDF RAM read port (1-cycle latency)
//   o_lut_addr, o_lut_data, o_lut_we      LUT RAM write port
//   o_busy, o_done     build in progress / completion pulse
module heq_lut_builder
  import heq_pkg::*;
#(
  parameter int DataWidth  = DATA_W,
  parameter int PixelCount = PIXEL_COUNT,
  parameter int CountWidth = COUNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [CountWidth-1:0] i_cdf_min,
  output logic [DataWidth-1:0]  o_cdf_addr,
  output logic                  o_cdf_rd_en,
  input  logic [CountWidth-1:0] i_cdf_data,
  output logic [DataWidth-1:0]  o_lut_addr,
  output logic [DataWidth-1:0]  o_lut_data,
  output logic                  o_lut_we,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NumWidth = CountWidth + DataWidth;
  localparam logic [DataWidth-1:0]  MaxLevel    = '1;
  localparam logic [CountWidth-1:0] PixelCountC = CountWidth'(PixelCount);

  heq_state_t            r_state;
  heq_state_t            w_state_next;
  logic [DataWidth-1:0]  r_bin;
  logic [CountWidth-1:0] r_cdf_min;
  logic [CountWidth-1:0] r_den;

  logic                  w_den_zero;
  logic [CountWidth-1:0] w_diff;
  logic [NumWidth-1:0]   w_diff_ext;
  logic [NumWidth-1:0]   w_num;
  logic                  w_div_load;
  logic [NumWidth-1:0]   w_quot;
  logic                  w_div_valid;
  logic [DataWidth-1:0]  w_lut_value;

  assign w_den_zero = (r_den == '0);

  // Bins below cdfMin clamp to zero instead of wrapping.
  assign w_diff     = (i_cdf_data > r_cdf_min) ? (i_cdf_data - r_cdf_min) : '0;
  assign w_diff_ext = NumWidth'(w_diff);

`ifdef HEQ_ROUND_EN
  // diff * (2^DataWidth - 1) as shift-and-subtract, plus half the divisor.
  assign w_num = (w_diff_ext << DataWidth) - w_diff_ext + NumWidth'(r_den >> 1);
`else
  assign w_num = (w_diff_ext << DataWidth) - w_diff_ext;
`endif

  // A uniform image (den == 0) bypasses the divider entirely.
  assign w_div_load = (r_state == ST_CALC) && !w_den_zero;

  heq_seq_divider #(
    .NumWidth (NumWidth),
    .DenWidth (CountWidth)
  ) u_div (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (w_div_load),
    .i_num     (w_num),
    .i_den     (r_den),
    .o_quot    (w_quot),
    .o_valid   (w_div_valid)
  );

  always_comb begin
    if (w_den_zero) begin
      w_lut_value = r_bin;
    end else if (|w_quot[NumWidth-1:DataWidth]) begin
      w_lut_value = MaxLevel;
    end else begin
      w_lut_value = w_quot[DataWidth-1:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_state_next = ST_READ;
      ST_READ:  w_state_next = ST_WAIT;
      ST_WAIT:  w_state_next = ST_CALC;
      ST_CALC:  w_state_next = w_den_zero ? ST_WRITE : ST_DIV;
      // o_valid marks the final step cycle, so the quotient is complete in WRITE.
      ST_DIV:   if (w_div_valid) w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = (r_bin == MaxLevel) ? ST_DONE : ST_READ;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cdf_rd_en = 1'b0;
    o_cdf_addr  = '0;
    o_lut_we    = 1'b0;
    o_lut_addr  = '0;
    o_lut_data  = '0;
    o_done      = 1'b0;
    o_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    case (r_state)
      ST_READ: begin
        o_cdf_rd_en = 1'b1;
        o_cdf_addr  = r_bin;
      end
      ST_WRITE: begin
        o_lut_we   = 1'b1;
        o_lut_addr = r_bin;
        o_lut_data = w_lut_value;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_cdf_min <= '0;
      r_den     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && i_start) begin
        r_cdf_min <= i_cdf_min;
        r_den     <= PixelCountC - i_cdf_min;
        r_bin     <= '0;
      end else if (r_state == ST_WRITE && r_bin != MaxLevel) begin
        r_bin <= r_bin + DataWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_heq_lut_builder.sv
// tb_heq_lut_builder: table-driven bench for heq_lut_builder plus hand-written
// sequences for reset, mid-build reset and the rounding case (second
// instance with PixelCount = 511).
module tb_heq_lut_builder;
  import heq_pkg::*;

  localparam int CW = COUNT_W;
  localparam int DW = DATA_W;

  localparam int P_RAMP = 0;  // cdf[v] = (v+1)*1200
  localparam int P_UNIF = 1;  // cdf[v] = 307200
  localparam int P_TWO  = 2;  // cdf[0..254] = 153600, cdf[255] = 307200
  localparam int P_LOW  = 3;  // cdf[v] = v*1200
  localparam int P_OVER = 4;  // cdf[v] = 524287 (forces saturation)

  typedef struct {
    int pattern;
    int cdf_min;
    bit extra_start;
    int exp_cycles;
    int p0; int e0;
    int p1; int e1;
    int p2; int e2;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start;
  logic [CW-1:0] cdf_min, cdf_data;
  logic [DW-1:0] cdf_addr, lut_addr, lut_data;
  logic          cdf_rd_en, lut_we, busy, done;

  logic          start_r;
  logic [CW-1:0] cdf_min_r, cdf_data_r;
  logic [DW-1:0] cdf_addr_r, lut_addr_r, lut_data_r;
  logic          cdf_rd_en_r, lut_we_r, busy_r, done_r;

  logic [CW-1:0] cdf_mem   [LUT_DEPTH];
  logic [CW-1:0] cdf_mem_r [LUT_DEPTH];

  always @(posedge clk) if (cdf_rd_en)   cdf_data   <= cdf_mem[cdf_addr];
  always @(posedge clk) if (cdf_rd_en_r) cdf_data_r <= cdf_mem_r[cdf_addr_r];

  heq_lut_builder u_dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_start     (start),
    .i_cdf_min   (cdf_min),
    .o_cdf_addr  (cdf_addr),
    .o_cdf_rd_en (cdf_rd_en),
    .i_cdf_data  (cdf_data),
    .o_lut_addr  (lut_addr),
    .o_lut_data  (lut_data),
    .o_lut_we    (lut_we),
    .o_busy      (busy),
    .o_done      (done)
  );

  heq_lut_builder #(.PixelCount(511)) u_dut_r (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_start     (start_r),
    .i_cdf_min   (cdf_min_r),
    .o_cdf_addr  (cdf_addr_r),
    .o_cdf_rd_en (cdf_rd_en_r),
    .i_cdf_data  (cdf_data_r),
    .o_lut_addr  (lut_addr_r),
    .o_lut_data  (lut_data_r),
    .o_lut_we    (lut_we_r),
    .o_busy      (busy_r),
    .o_done      (done_r)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic fill(input int pattern);
    for (int v = 0; v < LUT_DEPTH; v++) begin
      case (pattern)
        P_RAMP:  cdf_mem[v] = CW'((v + 1) * 1200);
        P_UNIF:  cdf_mem[v] = CW'(307200);
        P_TWO:   cdf_mem[v] = (v < 255) ? CW'(153600) : CW'(307200);
        P_LOW:   cdf_mem[v] = CW'(v * 1200);
        default: cdf_mem[v] = CW'(524287);
      endcase
    end
  endtask

  task automatic run_build(input int idx, input vec_t v);
    int wcnt, next_addr, order_err, done_cnt, done_cyc;
    logic [DW-1:0] got [LUT_DEPTH];
    fill(v.pattern);
    @(negedge clk);
    cdf_min = CW'(v.cdf_min);
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wcnt      = 0;
    next_addr = 0;
    order_err = 0;
    done_cnt  = 0;
    done_cyc  = 0;
    for (int v2 = 0; v2 < LUT_DEPTH; v2++) got[v2] = '0;
    chk($sformatf("v%0d_busy_after_start", idx), busy, 1);
    for (int n = 0; n < 9000; n++) begin
      if (n > 0) begin
        @(negedge clk);
        start = 1'b0;
      end
      if (lut_we) begin
        if (int'(lut_addr) != next_addr) order_err++;
        got[lut_addr] = lut_data;
        next_addr++;
        wcnt++;
        if (v.extra_start && (lut_addr == 8'd5 || lut_addr == 8'd200)) start = 1'b1;
      end
      if (done_cnt > 0 && n == done_cyc) begin
        chk($sformatf("v%0d_busy_after_done", idx), busy, 0);
        chk($sformatf("v%0d_done_one_cycle", idx), done, 0);
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = n + 1;
      end
      if (done_cnt > 0 && n >= done_cyc + 3) break;
    end
    chk($sformatf("v%0d_done_count", idx), done_cnt, 1);
    chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_cycles);
    chk($sformatf("v%0d_writes", idx), wcnt, LUT_DEPTH);
    chk($sformatf("v%0d_order_errors", idx), order_err, 0);
    chk($sformatf("v%0d_lut%0d", idx, v.p0), got[v.p0], v.e0);
    chk($sformatf("v%0d_lut%0d", idx, v.p1), got[v.p1], v.e1);
    chk($sformatf("v%0d_lut%0d", idx, v.p2), got[v.p2], v.e2);
    $display("vec %0d pattern=%0d cdf_min=%0d cycles=%0d writes=%0d lut[%0d]=%0d lut[%0d]=%0d lut[%0d]=%0d",
             idx, v.pattern, v.cdf_min, done_cyc, wcnt,
             v.p0, got[v.p0], v.p1, got[v.p1], v.p2, got[v.p2]);
  endtask

  vec_t vecs [6];

  initial begin
    int hit, stray, seen;
    int r3, r255;

    //           pattern cdf_min extra cycles  p0  e0   p1  e1   p2  e2
    vecs[0] = '{P_RAMP,  1,      1'b1, 7937,  127, 127, 191, 191, 255, 255};
    vecs[1] = '{P_UNIF,  307200, 1'b0, 1025,  0,   0,   77,  77,  255, 255};
    vecs[2] = '{P_TWO,   153600, 1'b0, 7937,  0,   0,   254, 0,   255, 255};
    vecs[3] = '{P_RAMP,  1200,   1'b0, 7937,  0,   0,   100, 100, 255, 255};
    vecs[4] = '{P_LOW,   2400,   1'b0, 7937,  0,   0,   1,   0,   2,   0};
    vecs[5] = '{P_OVER,  0,      1'b0, 7937,  0,   255, 128, 255, 255, 255};

    reset_n   = 1'b0;
    start     = 1'b0;
    cdf_min   = '0;
    start_r   = 1'b0;
    cdf_min_r = '0;
    for (int v = 0; v < LUT_DEPTH; v++) cdf_mem_r[v] = CW'(v + 1);

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_lut_we", lut_we, 0);
    chk("reset_rd_en", cdf_rd_en, 0);
    chk("reset_addrs_data", {cdf_addr, lut_addr, lut_data}, 0);

    // Start while reset is still asserted must be ignored.
    start   = 1'b1;
    cdf_min = CW'(1);
    @(negedge clk);
    start = 1'b0;
    chk("start_during_reset_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset_release", busy, 0);
    $display("txn reset: outputs idle, start during reset ignored");

    for (int i = 0; i < 6; i++) run_build(i, vecs[i]);

    // Mid-build reset at the WRITE of bin 100.
    fill(P_RAMP);
    @(negedge clk);
    cdf_min = CW'(1200);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit   = 0;
    for (int n = 0; n < 5000; n++) begin
      if (lut_we && lut_addr == 8'd100) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("midreset_reached_bin100", hit, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_lut_we", lut_we, 0);
    reset_n = 1'b1;
    stray   = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (lut_we || done || busy) stray++;
    end
    chk("midreset_quiet", stray, 0);
    $display("txn midreset: stray_activity=%0d", stray);
    run_build(6, vecs[3]);

    // Rounding instance: PixelCount = 511, cdfMin = 1, cdf[v] = v+1.
    @(negedge clk);
    cdf_min_r = CW'(1);
    start_r   = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    seen    = 0;
    r3      = -1;
    r255    = -1;
    for (int n = 0; n < 9000; n++) begin
      if (lut_we_r && lut_addr_r == 8'd3)   r3   = int'(lut_data_r);
      if (lut_we_r && lut_addr_r == 8'd255) r255 = int'(lut_data_r);
      if (done_r) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("round_done_seen", seen, 1);
`ifdef HEQ_ROUND_EN
    chk("round_lut3", r3, 2);
    chk("round_lut255", r255, 128);
`else
    chk("round_lut3", r3, 1);
    chk("round_lut255", r255, 127);
`endif
    $display("txn rounding: lut[3]=%0d lut[255]=%0d", r3, r255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
